pipe_skid_stage: RTL
====================

// Module: pipe_skid_stage
// PURPOSE
//  Parametrised pipeline register with valid/ready handshake and a 2-entry skid buffer.
//  Successor to the plain hold-flag DFF stage: back-pressure replaces the hold flag, a flush
//  input is added, and full throughput is kept with registered in_ready.
//  Sits between core pipeline stages (IF/ID/EX/MEM) where the consumer can stall.
// PARAMETERS
//  DATA_WIDTH    32  width of the payload carried through the stage
//  FLUSH_TO_RST  1   1: flush loads rst_value into both data regs; 0: flush leaves data regs unchanged
// PORTS
//  clk        in   1           clock, all state updates on posedge
//  rst        in   1           synchronous reset, active low
//  rst_value  in   DATA_WIDTH  value loaded into data regs on reset (and on flush if FLUSH_TO_RST=1)
//  in_valid   in   1           producer presents in_data
//  in_ready   out  1           stage can accept; registered
//  in_data    in   DATA_WIDTH  payload from producer
//  in_flush   in   1           discard all held entries (branch mispredict / trap)
//  out_valid  out  1           out_data holds a valid entry; registered
//  out_ready  in   1           consumer accepts out_data this cycle
//  out_data   out  DATA_WIDTH  head entry; driven directly from the main register
//  occupancy  out  2           held entries: 0, 1 or 2
// BEHAVIOUR
//  - Clock/reset: one clock clk; rst synchronous, active low.
//  - Storage: main reg (drives out_data) and skid reg. States: EMPTY(0), BUSY(1), FULL(2).
//  - Transfers: in_xfer = in_valid & in_ready; out_xfer = out_valid & out_ready.
//  - Reset (rst==0 at posedge): state EMPTY; main, skid <= rst_value.
//    Next cycle: out_valid=0, in_ready=1, occupancy=0, out_data=rst_value. in_* ignored while rst==0.
//  - Flush (rst==1, in_flush==1): state EMPTY.
//    Any in_xfer and out_xfer in that cycle are void; the entry is lost and the producer must not count it.
//    Data regs <= rst_value if FLUSH_TO_RST=1, otherwise unchanged.
//  - Priority: rst > in_flush > normal operation.
//  - EMPTY: in_xfer -> main<=in_data, BUSY. Otherwise stay.
//  - BUSY:
//      in_xfer & out_xfer   -> main<=in_data, stay BUSY
//      in_xfer & !out_xfer  -> skid<=in_data, FULL
//      !in_xfer & out_xfer  -> EMPTY; main keeps its last value
//      neither              -> stay
//  - FULL: in_ready=0. out_xfer -> main<=skid, BUSY. Otherwise stay.
//  - in_ready = (next_state != FULL), registered. Never combinationally depends on out_ready.
//  - out_valid = (state != EMPTY). occupancy = state encoding.
//  - Latency: 1 cycle, from in_xfer to out_valid/out_data.
//  - Throughput: 1 entry/cycle while out_ready stays high.
//  - Ordering: entries leave in acceptance order, with no loss or duplication except on flush.
//  - out_data must stay stable while out_valid=1 and out_ready=0.
//  - No arithmetic; payload passes bit-exact at any DATA_WIDTH>=1.
// TESTING
//  1 Reset with rst_value=32'hDEAD_BEEF, in_valid=1
//      -> after release: out_valid=0, in_ready=1, occupancy=0, out_data=32'hDEADBEEF.
//  2 Stream 1,2,...,8 on consecutive cycles, out_ready=1
//      -> out_data shows 1..8 one cycle later, back to back; occupancy never exceeds 1.
//  3 out_ready=0, send A=5 then B=6
//      -> occupancy=2, in_ready=0, out_data=5 held.
//      Raise out_ready: 5 then 6 emitted, in_ready returns to 1 a cycle after the first pop.
//  4 FULL state, then in_flush=1 with in_valid=1 (data 9), FLUSH_TO_RST=1
//      -> next cycle out_valid=0, occupancy=0, out_data=rst_value; 9 never appears.
//  5 rst pulled low in FULL state with out_ready toggling
//      -> reset values next cycle; no stale entry emitted afterward.
//  6 Random valid/ready, 10k cycles, scoreboard
//      -> in-order, lossless delivery; stability assertion passes; in_ready never high in FULL.

Source files
------------

// File: rtl/pipe_skid_stage_if.sv
// Valid/ready payload channel shared by the producer and consumer sides of a pipeline stage.
// The master drives valid and data; the slave answers with ready.
interface pipe_skid_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_skid_stage.sv
// Pipeline register with a 2-entry skid buffer and flush; 1-cycle latency, 1 entry/cycle.
// Backpressure: registered in_ready drops only when both entries are held, never from out_ready directly.
module pipe_skid_stage #(
    parameter int DATA_WIDTH   = 32,
    parameter bit FLUSH_TO_RST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rst_value,
    input  logic                  in_flush,
    pipe_skid_stage_if.slave      in_if,
    pipe_skid_stage_if.master     out_if,
    output logic [1:0]            occupancy
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] main_dat;
    logic [DATA_WIDTH-1:0] main_nxt;
    logic [DATA_WIDTH-1:0] skid_dat;
    logic [DATA_WIDTH-1:0] skid_nxt;
    logic                  in_rdy;
    logic                  in_xfer;
    logic                  out_xfer;

    assign in_xfer  = in_if.valid & in_rdy;
    assign out_xfer = (state != EMPTY) & out_if.ready;

    always_comb begin
        state_nxt = state;
        main_nxt  = main_dat;
        skid_nxt  = skid_dat;
        if (in_flush) begin
            // Both transfers of this cycle are voided; the flushed entry is simply dropped.
            state_nxt = EMPTY;
            if (FLUSH_TO_RST) begin
                main_nxt = rst_value;
                skid_nxt = rst_value;
            end
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        main_nxt  = in_if.data;
                        state_nxt = BUSY;
                    end
                end
                BUSY: begin
                    if (in_xfer && out_xfer) begin
                        main_nxt = in_if.data;
                    end else if (in_xfer) begin
                        skid_nxt  = in_if.data;
                        state_nxt = FULL;
                    end else if (out_xfer) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        main_nxt  = skid_dat;
                        state_nxt = BUSY;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= EMPTY;
            main_dat <= rst_value;
            skid_dat <= rst_value;
            in_rdy   <= 1'b1;
        end else begin
            state    <= state_nxt;
            main_dat <= main_nxt;
            skid_dat <= skid_nxt;
            in_rdy   <= (state_nxt != FULL);
        end
    end

    assign in_if.ready  = in_rdy;
    assign out_if.valid = (state != EMPTY);
    assign out_if.data  = main_dat;
    assign occupancy    = state;
endmodule
